// File: rtl/layer_priority_mux.sv
// layer_priority_mux: N-layer priority pixel compositor, 2-clock latency, 1 pixel/clock, never stalls.
// Optional macro LAYER_MUX_COLLISION_EN adds the per-frame collisionFlags output and its accumulator.
module layer_priority_mux #(
  parameter int                 NUM_LAYERS  = 8,
  parameter int                 RGB_W       = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT = 8'hFF,
  parameter logic [RGB_W-1:0]   BACKGROUND  = 8'h00
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_LAYERS-1:0]               layerDR,
  input  logic [NUM_LAYERS*RGB_W-1:0]         RGBLayers,
  input  logic                                pixelValid,
  input  logic                                startOfFrame,
  input  logic                                cfgWrite,
  input  logic [NUM_LAYERS-1:0]               cfgMask,
  output logic                                cfgReady,
  output logic [RGB_W-1:0]                    RGBOut,
  output logic                                RGBValid,
  output logic [$clog2(NUM_LAYERS+1)-1:0]     topLayer
`ifdef LAYER_MUX_COLLISION_EN
  ,
  output logic [NUM_LAYERS-1:0]               collisionFlags
`endif
);

  localparam int              IDX_W  = $clog2(NUM_LAYERS+1);
  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] activeMask;
  logic [NUM_LAYERS-1:0] pendingMask;
  logic                  pendingVld;
  logic                  applyMask;
  logic [NUM_LAYERS-1:0] effMask;
  logic [NUM_LAYERS-1:0] qual;
  logic [IDX_W-1:0]      winIdx;
  logic [RGB_W-1:0]      winRgb;

  logic                  s1Vld;
  logic [IDX_W-1:0]      s1Idx;
  logic [RGB_W-1:0]      s1Rgb;

  // A pending mask takes effect on the startOfFrame pixel itself, so bypass it in.
  always_comb begin
    applyMask = startOfFrame & pendingVld;
    effMask   = applyMask ? pendingMask : activeMask;
  end

  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      qual[i] = layerDR[i] & effMask[i] & pixelValid &
                (RGBLayers[i*RGB_W +: RGB_W] != TRANSPARENT);
    end
  end

  // Scan from lowest priority upward so the lowest qualifying index wins.
  always_comb begin
    winIdx = BG_IDX;
    winRgb = BACKGROUND;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (qual[i]) begin
        winIdx = IDX_W'(i);
        winRgb = RGBLayers[i*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activeMask  <= '1;
      pendingMask <= '0;
      pendingVld  <= 1'b0;
    end else if (cfgWrite && !pendingVld) begin
      pendingMask <= cfgMask;
      pendingVld  <= 1'b1;
    end else if (applyMask) begin
      activeMask  <= pendingMask;
      pendingVld  <= 1'b0;
    end
  end

  assign cfgReady = ~pendingVld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Vld    <= 1'b0;
      s1Idx    <= BG_IDX;
      s1Rgb    <= BACKGROUND;
      RGBValid <= 1'b0;
      topLayer <= BG_IDX;
      RGBOut   <= '0;
    end else begin
      s1Vld    <= pixelValid;
      s1Idx    <= winIdx;
      s1Rgb    <= winRgb;
      RGBValid <= s1Vld;
      topLayer <= s1Idx;
      RGBOut   <= s1Rgb;
    end
  end

`ifdef LAYER_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] collAcc;
  logic                  collide;

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign collide = |(qual & (qual - NUM_LAYERS'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collAcc        <= '0;
      collisionFlags <= '0;
    end else if (startOfFrame) begin
      collisionFlags <= collAcc;
      collAcc        <= collide ? qual : '0;
    end else if (collide) begin
      collAcc        <= collAcc | qual;
    end
  end
`else
  // Collision tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux: priority, transparency, mask timing, pipeline and reset.
module tb_layer_priority_mux;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  layerDR = '0;
  logic [63:0] RGBLayers = '0;
  logic        pixelValid = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        cfgWrite = 1'b0;
  logic [7:0]  cfgMask = '0;
  logic        cfgReady;
  logic [7:0]  RGBOut;
  logic        RGBValid;
  logic [3:0]  topLayer;
`ifdef LAYER_MUX_COLLISION_EN
  logic [7:0]  collisionFlags;
`endif

  int tests = 0;
  int fails = 0;
  logic [12:0] e1, e2, cur;

  always #5 clk = ~clk;

  layer_priority_mux #(
    .NUM_LAYERS(8), .RGB_W(8), .TRANSPARENT(8'hFF), .BACKGROUND(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .layerDR(layerDR), .RGBLayers(RGBLayers),
    .pixelValid(pixelValid), .startOfFrame(startOfFrame), .cfgWrite(cfgWrite),
    .cfgMask(cfgMask), .cfgReady(cfgReady), .RGBOut(RGBOut), .RGBValid(RGBValid),
    .topLayer(topLayer)
`ifdef LAYER_MUX_COLLISION_EN
    , .collisionFlags(collisionFlags)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    layerDR = '0; pixelValid = 1'b0; startOfFrame = 1'b0; cfgWrite = 1'b0;
  endtask

  task automatic pix(input logic [7:0] dr);
    layerDR = dr; pixelValid = 1'b1;
  endtask

  // Reference compositor with every layer enabled: {valid, index, colour}.
  function automatic logic [12:0] model(input logic [7:0] dr, input logic [63:0] rgb, input logic pv);
    logic [12:0] r;
    r = {pv, 4'd8, 8'h00};
    for (int i = 7; i >= 0; i--)
      if (pv && dr[i] && rgb[i*8 +: 8] != 8'hFF) r = {pv, 4'(i), rgb[i*8 +: 8]};
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b1; idle(); RGBLayers = '0;
    tick();
    tests++; if (RGBOut !== 8'h00) begin fails++; $display("FAIL reset_rgb got=%h exp=00", RGBOut); end
    tests++; if (RGBValid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", RGBValid); end
    tests++; if (topLayer !== 4'd8) begin fails++; $display("FAIL reset_top got=%0d exp=8", topLayer); end
    tests++; if (cfgReady !== 1'b1) begin fails++; $display("FAIL reset_rdy got=%b exp=1", cfgReady); end
`ifdef LAYER_MUX_COLLISION_EN
    tests++; if (collisionFlags !== 8'h00) begin fails++; $display("FAIL reset_coll got=%h exp=00", collisionFlags); end
`endif
    reset = 1'b0;
    RGBLayers[56 +: 8] = 8'h55; pix(8'h80);
    tick(); idle(); tick();
    tests++;
    if (RGBOut !== 8'h55 || topLayer !== 4'd7 || RGBValid !== 1'b1) begin
      fails++; $display("FAIL reset_mask_all_ones got=%h/%0d/%b exp=55/7/1", RGBOut, topLayer, RGBValid);
    end
  endtask

  task automatic test_priority;
    RGBLayers = '0; RGBLayers[8 +: 8] = 8'h1C; RGBLayers[16 +: 8] = 8'hE0;
    pix(8'b0000_0110);
    tick(); idle();
    tests++; if (RGBValid !== 1'b0) begin fails++; $display("FAIL prio_latency valid got=%b exp=0", RGBValid); end
    tick();
    tests++;
    if (RGBOut !== 8'h1C || topLayer !== 4'd1 || RGBValid !== 1'b1) begin
      fails++; $display("FAIL prio got=%h/%0d/%b exp=1c/1/1", RGBOut, topLayer, RGBValid);
    end
    tick();
    tests++;
    if (RGBOut !== 8'h00 || topLayer !== 4'd8 || RGBValid !== 1'b0) begin
      fails++; $display("FAIL prio_idle got=%h/%0d/%b exp=00/8/0", RGBOut, topLayer, RGBValid);
    end
  endtask

  task automatic test_transparency;
    RGBLayers = '0; RGBLayers[0 +: 8] = 8'hFF; RGBLayers[8 +: 8] = 8'h03;
    pix(8'b0000_0011);
    tick();
    RGBLayers[8 +: 8] = 8'hFF;
    tick();
    tests++;
    if (RGBOut !== 8'h03 || topLayer !== 4'd1 || RGBValid !== 1'b1) begin
      fails++; $display("FAIL transp_skip got=%h/%0d/%b exp=03/1/1", RGBOut, topLayer, RGBValid);
    end
    layerDR = 8'h01; RGBLayers[0 +: 8] = 8'h11; pixelValid = 1'b0;
    tick();
    tests++;
    if (RGBOut !== 8'h00 || topLayer !== 4'd8 || RGBValid !== 1'b1) begin
      fails++; $display("FAIL transp_all got=%h/%0d/%b exp=00/8/1", RGBOut, topLayer, RGBValid);
    end
    idle();
    tick();
    tests++;
    if (RGBOut !== 8'h00 || topLayer !== 4'd8 || RGBValid !== 1'b0) begin
      fails++; $display("FAIL invalid_pixel got=%h/%0d/%b exp=00/8/0", RGBOut, topLayer, RGBValid);
    end
  endtask

  task automatic test_mask;
    RGBLayers = '0; RGBLayers[0 +: 8] = 8'h11; RGBLayers[8 +: 8] = 8'h22;
    pix(8'b0000_0011);
    tick(); tick();
    tests++; if (RGBOut !== 8'h11 || topLayer !== 4'd0) begin fails++; $display("FAIL mask_pre got=%h/%0d exp=11/0", RGBOut, topLayer); end
    cfgWrite = 1'b1; cfgMask = 8'hFE;
    tick(); cfgWrite = 1'b0;
    tests++; if (cfgReady !== 1'b0 || RGBOut !== 8'h11) begin fails++; $display("FAIL mask_pending got=%b/%h exp=0/11", cfgReady, RGBOut); end
    cfgWrite = 1'b1; cfgMask = 8'h00;
    tick(); cfgWrite = 1'b0;
    tests++; if (cfgReady !== 1'b0 || RGBOut !== 8'h11) begin fails++; $display("FAIL mask_second_write got=%b/%h exp=0/11", cfgReady, RGBOut); end
    startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tests++;
    if (cfgReady !== 1'b1 || RGBOut !== 8'h11 || topLayer !== 4'd0) begin
      fails++; $display("FAIL mask_inflight got=%b/%h/%0d exp=1/11/0", cfgReady, RGBOut, topLayer);
    end
    tick();
    tests++; if (RGBOut !== 8'h22 || topLayer !== 4'd1) begin fails++; $display("FAIL mask_sof_pixel got=%h/%0d exp=22/1", RGBOut, topLayer); end
    tick();
    tests++; if (RGBOut !== 8'h22 || topLayer !== 4'd1) begin fails++; $display("FAIL mask_ignored_write got=%h/%0d exp=22/1", RGBOut, topLayer); end
    cfgWrite = 1'b1; cfgMask = 8'hFF; startOfFrame = 1'b1;
    tick(); cfgWrite = 1'b0; startOfFrame = 1'b0;
    tests++; if (cfgReady !== 1'b0) begin fails++; $display("FAIL mask_sof_write_rdy got=%b exp=0", cfgReady); end
    tick(); tick();
    tests++; if (RGBOut !== 8'h22 || topLayer !== 4'd1) begin fails++; $display("FAIL mask_sof_write_deferred got=%h/%0d exp=22/1", RGBOut, topLayer); end
    startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tick();
    tests++;
    if (RGBOut !== 8'h11 || topLayer !== 4'd0 || cfgReady !== 1'b1) begin
      fails++; $display("FAIL mask_next_sof got=%h/%0d/%b exp=11/0/1", RGBOut, topLayer, cfgReady);
    end
    cfgWrite = 1'b1; cfgMask = 8'h00;
    tick(); cfgWrite = 1'b0; startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tick();
    tests++;
    if (RGBOut !== 8'h00 || topLayer !== 4'd8 || RGBValid !== 1'b1) begin
      fails++; $display("FAIL mask_zero got=%h/%0d/%b exp=00/8/1", RGBOut, topLayer, RGBValid);
    end
    cfgWrite = 1'b1; cfgMask = 8'hFF;
    tick(); cfgWrite = 1'b0; startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tick();
    tests++; if (RGBOut !== 8'h11 || topLayer !== 4'd0) begin fails++; $display("FAIL mask_restore got=%h/%0d exp=11/0", RGBOut, topLayer); end
    idle();
  endtask

  task automatic test_pipeline;
    idle(); tick(); tick();
    e1 = {1'b0, 4'd8, 8'h00};
    e2 = e1;
    for (int n = 0; n < 48; n++) begin
      layerDR    = 8'($urandom);
      pixelValid = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++)
        RGBLayers[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cur = model(layerDR, RGBLayers, pixelValid);
      tick();
      e2 = e1; e1 = cur;
      tests++;
      if ({RGBValid, topLayer, RGBOut} !== e2) begin
        fails++; $display("FAIL pipeline n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, RGBValid, topLayer, RGBOut, e2[12], e2[11:8], e2[7:0]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid;
    RGBLayers = '0; RGBLayers[0 +: 8] = 8'h11;
    cfgWrite = 1'b1; cfgMask = 8'hF0;
    tick(); cfgWrite = 1'b0;
    tests++; if (cfgReady !== 1'b0) begin fails++; $display("FAIL rstmid_pending got=%b exp=0", cfgReady); end
    pix(8'h01);
    tick(); tick();
    #1 reset = 1'b1;
    #1;
    tests++;
    if (RGBOut !== 8'h00 || RGBValid !== 1'b0 || topLayer !== 4'd8 || cfgReady !== 1'b1) begin
      fails++; $display("FAIL rstmid got=%h/%b/%0d/%b exp=00/0/8/1", RGBOut, RGBValid, topLayer, cfgReady);
    end
    tick();
    reset = 1'b0; startOfFrame = 1'b1; pix(8'h01);
    tick(); idle();
    tick();
    tests++; if (RGBOut !== 8'h11 || topLayer !== 4'd0) begin fails++; $display("FAIL rstmid_discard got=%h/%0d exp=11/0", RGBOut, topLayer); end
  endtask

`ifdef LAYER_MUX_COLLISION_EN
  task automatic test_collision;
    RGBLayers = '0; RGBLayers[8 +: 8] = 8'h22; RGBLayers[24 +: 8] = 8'h44;
    idle(); startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    pix(8'b0000_1010); tick();
    pix(8'b0000_0010); tick();
    idle(); tick();
    tests++; if (collisionFlags !== 8'h00) begin fails++; $display("FAIL coll_frame_n got=%h exp=00", collisionFlags); end
    startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tests++; if (collisionFlags !== 8'h0A) begin fails++; $display("FAIL coll_frame_n1 got=%h exp=0a", collisionFlags); end
    tick();
    tests++; if (collisionFlags !== 8'h0A) begin fails++; $display("FAIL coll_hold got=%h exp=0a", collisionFlags); end
    startOfFrame = 1'b1;
    tick(); startOfFrame = 1'b0;
    tests++; if (collisionFlags !== 8'h00) begin fails++; $display("FAIL coll_clear got=%h exp=00", collisionFlags); end
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_transparency();
    test_mask();
    test_pipeline();
    test_reset_mid();
`ifdef LAYER_MUX_COLLISION_EN
    test_collision();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
